// File: rtl/montexp_pkg.sv
// Shared definitions for the Montgomery modular exponentiation core and its multiplier.
package montexp_pkg;

    localparam int MONTEXP_WIDTH = 512;
    localparam int BIT_IDX_W     = $clog2(MONTEXP_WIDTH);
    // Multiplier latency from mm_start to mm_done at the default width
    localparam int T_MM          = MONTEXP_WIDTH + 2;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_TO_MONT   = 3'd2,
        ST_SQUARE    = 3'd3,
        ST_MULTIPLY  = 3'd4,
        ST_FROM_MONT = 3'd5,
        ST_DONE      = 3'd6
    } state_e;

endpackage

// File: rtl/mont_mul.sv
// Bit-serial radix-2 Montgomery multiplier: product = a*b*2^-WIDTH mod m, latency WIDTH+2.
module mont_mul import montexp_pkg::*; #(
    parameter int WIDTH = MONTEXP_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mm_start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] m,
    output logic             mm_done,
    output logic [WIDTH-1:0] product
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        MM_IDLE = 2'd0,
        MM_RUN  = 2'd1,
        MM_SUB  = 2'd2
    } mm_state_e;

    mm_state_e        state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, m_q, m_d;
    logic [WIDTH-1:0] product_q, product_d;
    logic [WIDTH:0]   acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic [WIDTH+1:0] sum_s, red_s;

    // Iteration datapath and sequencing; acc stays below 2m so one final subtract suffices
    always_comb begin
        sum_s     = {1'b0, acc_q} + (a_q[0] ? {2'b00, b_q} : {(WIDTH+2){1'b0}});
        red_s     = sum_s + (sum_s[0] ? {2'b00, m_q} : {(WIDTH+2){1'b0}});
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        m_d       = m_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        done_d    = 1'b0;
        case (state_q)
            MM_IDLE: begin
                if (mm_start) begin
                    a_d     = a;
                    b_d     = b;
                    m_d     = m;
                    acc_d   = {(WIDTH+1){1'b0}};
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = MM_RUN;
                end else begin
                    state_d = MM_IDLE;
                end
            end
            MM_RUN: begin
                acc_d = (WIDTH+1)'(red_s >> 1);
                a_d   = a_q >> 1;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = MM_SUB;
                end else begin
                    state_d = MM_RUN;
                end
            end
            MM_SUB: begin
                if (acc_q >= {1'b0, m_q}) begin
                    product_d = WIDTH'(acc_q - {1'b0, m_q});
                end else begin
                    product_d = acc_q[WIDTH-1:0];
                end
                done_d  = 1'b1;
                state_d = MM_IDLE;
            end
            default: begin
                state_d = MM_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= MM_IDLE;
            a_q       <= {WIDTH{1'b0}};
            b_q       <= {WIDTH{1'b0}};
            m_q       <= {WIDTH{1'b0}};
            acc_q     <= {(WIDTH+1){1'b0}};
            cnt_q     <= {CNT_W{1'b0}};
            product_q <= {WIDTH{1'b0}};
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            m_q       <= m_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
            done_q    <= done_d;
        end
    end

    assign mm_done = done_q;
    assign product = product_q;

endmodule

// File: rtl/mont_exp_core.sv
// Left-to-right binary modular exponentiation sequencing one mont_mul.
// Optional feature: MONTEXP_SKIP_LZ_EN starts the scan at the highest set exponent bit.
module mont_exp_core import montexp_pkg::*; #(
    parameter int WIDTH = MONTEXP_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] modulus,
    input  logic [WIDTH-1:0] Rmodm,
    input  logic [WIDTH-1:0] Rsquaredmodm,
    input  logic [WIDTH-1:0] exponent,
    input  logic [WIDTH-1:0] x,
    input  logic             multiplication_enable,
    output logic             done,
    output logic [WIDTH-1:0] A_result
);

    localparam int IDX_W = $clog2(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] m_q, m_d, e_q, e_d, x_q, x_d, r2_q, r2_d;
    logic [WIDTH-1:0] a_q, a_d, xt_q, xt_d, a_result_q, a_result_d;
    logic [IDX_W-1:0] bit_idx_q, bit_idx_d;
    logic             mul_en_q, mul_en_d, issued_q, issued_d;
    logic             mm_start_q, mm_start_d, done_q, done_d;
    logic [WIDTH-1:0] mm_a_s, mm_b_s, mm_product_s;
    logic             mm_done_s, skip_to_from_s;
    logic [IDX_W-1:0] load_idx_s;

`ifdef MONTEXP_SKIP_LZ_EN
    function automatic logic [IDX_W-1:0] msb_index(input logic [WIDTH-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = {IDX_W{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            if (v[i]) begin
                idx = IDX_W'(i);
            end
        end
        return idx;
    endfunction

    assign load_idx_s     = msb_index(exponent);
    assign skip_to_from_s = (e_q == {WIDTH{1'b0}});
`else
    assign load_idx_s     = IDX_W'(WIDTH - 1);
    assign skip_to_from_s = 1'b0;
`endif

    mont_mul #(.WIDTH(WIDTH)) u_mm (
        .clk      (clk),
        .reset    (reset),
        .mm_start (mm_start_q),
        .a        (mm_a_s),
        .b        (mm_b_s),
        .m        (m_q),
        .mm_done  (mm_done_s),
        .product  (mm_product_s)
    );

    // Operand mux; held stable for the whole state so mm_start always sees settled operands
    always_comb begin
        mm_a_s = {WIDTH{1'b0}};
        mm_b_s = {WIDTH{1'b0}};
        case (state_q)
            ST_TO_MONT:   begin mm_a_s = x_q; mm_b_s = r2_q;           end
            ST_SQUARE:    begin mm_a_s = a_q; mm_b_s = a_q;            end
            ST_MULTIPLY:  begin mm_a_s = a_q; mm_b_s = xt_q;           end
            ST_FROM_MONT: begin mm_a_s = a_q; mm_b_s = WIDTH'(1'b1);   end
            default:      begin mm_a_s = {WIDTH{1'b0}}; mm_b_s = {WIDTH{1'b0}}; end
        endcase
    end

    // Next-state logic: each product is captured on mm_done and the next op issued right after
    always_comb begin
        state_d    = state_q;
        m_d        = m_q;
        e_d        = e_q;
        x_d        = x_q;
        r2_d       = r2_q;
        a_d        = a_q;
        xt_d       = xt_q;
        a_result_d = a_result_q;
        bit_idx_d  = bit_idx_q;
        mul_en_d   = mul_en_q;
        issued_d   = issued_q;
        mm_start_d = 1'b0;
        done_d     = done_q;
        case (state_q)
            ST_IDLE: begin
                done_d   = 1'b0;
                issued_d = 1'b0;
                if (start) begin
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                m_d       = modulus;
                e_d       = exponent;
                x_d       = x;
                r2_d      = Rsquaredmodm;
                mul_en_d  = multiplication_enable;
                a_d       = Rmodm;
                xt_d      = {WIDTH{1'b0}};
                bit_idx_d = load_idx_s;
                state_d   = ST_TO_MONT;
            end
            ST_TO_MONT: begin
                if (!issued_q) begin
                    mm_start_d = 1'b1;
                    issued_d   = 1'b1;
                end else if (mm_done_s) begin
                    if (mul_en_q) begin
                        a_result_d = mm_product_s;
                        done_d     = 1'b1;
                        state_d    = ST_DONE;
                    end else begin
                        xt_d       = mm_product_s;
                        mm_start_d = 1'b1;
                        state_d    = skip_to_from_s ? ST_FROM_MONT : ST_SQUARE;
                    end
                end else begin
                    state_d = ST_TO_MONT;
                end
            end
            ST_SQUARE: begin
                if (mm_done_s) begin
                    a_d        = mm_product_s;
                    mm_start_d = 1'b1;
                    if (e_q[bit_idx_q]) begin
                        state_d = ST_MULTIPLY;
                    end else if (bit_idx_q == {IDX_W{1'b0}}) begin
                        state_d = ST_FROM_MONT;
                    end else begin
                        bit_idx_d = bit_idx_q - IDX_W'(1);
                        state_d   = ST_SQUARE;
                    end
                end else begin
                    state_d = ST_SQUARE;
                end
            end
            ST_MULTIPLY: begin
                if (mm_done_s) begin
                    a_d        = mm_product_s;
                    mm_start_d = 1'b1;
                    if (bit_idx_q == {IDX_W{1'b0}}) begin
                        state_d = ST_FROM_MONT;
                    end else begin
                        bit_idx_d = bit_idx_q - IDX_W'(1);
                        state_d   = ST_SQUARE;
                    end
                end else begin
                    state_d = ST_MULTIPLY;
                end
            end
            ST_FROM_MONT: begin
                if (mm_done_s) begin
                    a_result_d = mm_product_s;
                    done_d     = 1'b1;
                    state_d    = ST_DONE;
                end else begin
                    state_d = ST_FROM_MONT;
                end
            end
            ST_DONE: begin
                if (!start) begin
                    done_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                done_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, operand and result registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            m_q        <= {WIDTH{1'b0}};
            e_q        <= {WIDTH{1'b0}};
            x_q        <= {WIDTH{1'b0}};
            r2_q       <= {WIDTH{1'b0}};
            a_q        <= {WIDTH{1'b0}};
            xt_q       <= {WIDTH{1'b0}};
            a_result_q <= {WIDTH{1'b0}};
            bit_idx_q  <= {IDX_W{1'b0}};
            mul_en_q   <= 1'b0;
            issued_q   <= 1'b0;
            mm_start_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            m_q        <= m_d;
            e_q        <= e_d;
            x_q        <= x_d;
            r2_q       <= r2_d;
            a_q        <= a_d;
            xt_q       <= xt_d;
            a_result_q <= a_result_d;
            bit_idx_q  <= bit_idx_d;
            mul_en_q   <= mul_en_d;
            issued_q   <= issued_d;
            mm_start_q <= mm_start_d;
            done_q     <= done_d;
        end
    end

    assign done     = done_q;
    assign A_result = a_result_q;

endmodule
